// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch handshake.
// Optional build macro MISALIGN_TRAP_EN adds the misalign_err port and ERR state.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef MISALIGN_TRAP_EN
    ,
    S_ERR  = 2'd3
`endif
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc;
  logic [31:0] load_val;
  logic        discard, discard_d;
  logic        pc_load;
  logic        capture;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign out_valid = (state == S_HOLD);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign load_val     = next_pc;
  assign misaligned   = |next_pc[1:0];
  assign misalign_err = (state == S_ERR);
`else
  assign load_val = next_pc & 32'hFFFF_FFFC;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state;
    discard_d      = discard;
    pc_load        = 1'b0;
    capture        = 1'b0;
    imem_req_valid = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
        if (redirect) begin
          pc_load = 1'b1;
          // A request accepted in the same cycle as a redirect fetched the old path.
          if (imem_req_ready) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          if (discard || redirect) begin
            state_d = S_REQ;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end
        if (redirect) begin
          pc_load = 1'b1;
          if (!imem_rsp_valid) discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || out_ready) begin
          pc_load = 1'b1;
          state_d = S_REQ;
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_ERR: begin
        // A stale response may still be owed; swallow it here or in WAIT after exit.
        if (imem_rsp_valid) discard_d = 1'b0;
        if (redirect) begin
          pc_load = 1'b1;
          state_d = (discard && !imem_rsp_valid) ? S_WAIT : S_REQ;
        end
      end
`endif
      default: state_d = S_REQ;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (pc_load && misaligned) state_d = S_ERR;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      out_pc    <= 32'h0;
      out_instr <= 32'h0;
    end else begin
      state   <= state_d;
      discard <= discard_d;
      if (pc_load) pc <= load_val;
      if (capture) begin
        out_pc    <= pc;
        out_instr <= imem_rsp_data;
      end
    end
  end

endmodule
